battle_datapath: RTL and testbench

- Datapath responder for the battle control FSM. It consumes that FSM's one-hot-per-state control strobes and holds both Pokemon's HP, and produces the status flags the FSM branches on: ai_dead, p_dead and catch_success.
- It adds pseudo-random damage variance and catch rolls from an internal LFSR, a limited heal budget, a turn counter and battle-over freezing.

---
 rtl/battle_datapath.sv | 128 ++++++++++++
 tb/tb_battle_datapath.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/battle_datapath.sv
// Battle datapath: both Pokemon's HP, damage/heal/catch arithmetic, an LFSR for
// variance and catch rolls, turn/fail counters and a latch that freezes the battle.
module battle_datapath #(
  parameter int HP_W       = 8,
  parameter int P_MAX_HP   = 100,
  parameter int AI_MAX_HP  = 100,
  parameter int P_ATK      = 20,
  parameter int AI_ATK     = 15,
  parameter int HEAL_AMT   = 30,
  parameter int HEAL_USES  = 3,
  parameter int CATCH_BASE = 16,
  parameter int VAR_EN     = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_ai_hp,
  input  logic            apply_ai_damage,
  input  logic            apply_p_damage,
  input  logic            active_trainer,
  input  logic            target,
  input  logic            p_heal,
  input  logic            catch,
  input  logic            catch_fail,
  input  logic            caught,
  input  logic            victory,
  input  logic            loss,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            p_dead,
  output logic            ai_dead,
  output logic            catch_success,
  output logic [HP_W-1:0] last_dmg,
  output logic [HP_W-1:0] turn_count,
  output logic [2:0]      heals_left,
  output logic            heal_denied,
  output logic [HP_W-1:0] fail_count,
  output logic            cmd_err
);

  localparam logic [HP_W-1:0] P_MAX  = HP_W'(P_MAX_HP);
  localparam logic [HP_W-1:0] AI_MAX = HP_W'(AI_MAX_HP);

  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic            frozen;
  logic            stop_now;
  logic            hold;
  logic [HP_W-1:0] var_add;
  logic [HP_W-1:0] dmg_ai;
  logic [HP_W-1:0] dmg_p;
  logic            ai_ok;
  logic            p_ok;
  logic            bad_cmd;
  logic            heal_ok;
  logic [HP_W:0]   heal_sum;
  logic [HP_W-1:0] p_healed;
  logic [HP_W-1:0] p_base;
  logic [HP_W-1:0] p_next;
  logic [HP_W-1:0] ai_next;
  logic [9:0]      thresh_wide;
  logic [7:0]      thresh;

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                               input logic [HP_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  // Galois right-shift LFSR; a nonzero seed keeps it out of the all-zero lock-up state
  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  assign stop_now = victory | loss | caught;
  assign hold     = frozen | stop_now;

  assign var_add = (VAR_EN != 0) ? {{(HP_W-3){1'b0}}, lfsr[2:0]} : '0;
  assign dmg_ai  = HP_W'(P_ATK) + var_add;
  assign dmg_p   = HP_W'(AI_ATK) + var_add;

  assign ai_ok   = apply_ai_damage & target & ~active_trainer;
  assign p_ok    = apply_p_damage & ~target & active_trainer;
  assign bad_cmd = (apply_ai_damage & ~ai_ok) | (apply_p_damage & ~p_ok);

  // Heal is applied first so a same-cycle hit lands on the healed value
  assign heal_ok  = p_heal & (heals_left != 3'd0);
  assign heal_sum = {1'b0, p_hp} + (HP_W+1)'(HEAL_AMT);
  assign p_healed = (heal_sum > {1'b0, P_MAX}) ? P_MAX : heal_sum[HP_W-1:0];
  assign p_base   = heal_ok ? p_healed : p_hp;
  assign p_next   = p_ok ? sat_sub(p_base, dmg_p) : p_base;
  assign ai_next  = load_ai_hp ? AI_MAX : (ai_ok ? sat_sub(ai_hp, dmg_ai) : ai_hp);

  assign p_dead  = (p_hp == '0);
  assign ai_dead = (ai_hp == '0);

  // Catch threshold grows with damage taken by the AI, clamped to the 8-bit roll range
  assign thresh_wide   = 10'(CATCH_BASE) + 10'(AI_MAX_HP) - 10'(ai_hp);
  assign thresh        = (thresh_wide > 10'd255) ? 8'hFF : thresh_wide[7:0];
  assign catch_success = catch & ~frozen & (thresh != 8'd0) & (lfsr[7:0] <= thresh);

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr        <= 16'hACE1;
      frozen      <= 1'b0;
      p_hp        <= P_MAX;
      ai_hp       <= AI_MAX;
      last_dmg    <= '0;
      turn_count  <= '0;
      fail_count  <= '0;
      heals_left  <= 3'(HEAL_USES);
      heal_denied <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      lfsr        <= lfsr_next;
      heal_denied <= 1'b0;
      if (stop_now) frozen <= 1'b1;
      if (!hold) begin
        p_hp        <= p_next;
        ai_hp       <= ai_next;
        heal_denied <= p_heal & (heals_left == 3'd0);
        if (heal_ok) heals_left <= heals_left - 3'd1;
        if (p_ok) last_dmg <= dmg_p;
        else if (ai_ok & ~load_ai_hp) last_dmg <= dmg_ai;
        if (apply_p_damage && turn_count != '1) turn_count <= turn_count + 1'b1;
        if (catch_fail && fail_count != '1) fail_count <= fail_count + 1'b1;
        if (bad_cmd) cmd_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_battle_datapath.sv
// Bench for battle_datapath: two instances (deterministic/base-255 and variance/base-0)
// share one stimulus stream and are checked against an arithmetic model of the battle rules.
module tb_battle_datapath;

  logic clk = 1'b0;
  logic reset, load_ai_hp, apply_ai_damage, apply_p_damage, active_trainer, target;
  logic p_heal, catch, catch_fail, caught, victory, loss;

  logic [7:0] p_hp [2];
  logic [7:0] ai_hp [2];
  logic [7:0] last_dmg [2];
  logic [7:0] turn_count [2];
  logic [7:0] fail_count [2];
  logic [2:0] heals_left [2];
  logic       p_dead [2];
  logic       ai_dead [2];
  logic       catch_success [2];
  logic       heal_denied [2];
  logic       cmd_err [2];

  int checks = 0;
  int errors = 0;

  // Behavioural model state, one slot per instance
  int m_var [2] = '{0, 1};
  int m_cb  [2] = '{255, 0};
  int m_p [2], m_ai [2], m_last [2], m_turn [2], m_fail [2], m_heals [2];
  int m_den [2], m_err [2], m_frz [2];
  int m_lfsr;
  int seen;

  always #5 clk = ~clk;

  battle_datapath #(.VAR_EN(0), .CATCH_BASE(255)) dut0 (
    .clk(clk), .reset(reset), .load_ai_hp(load_ai_hp), .apply_ai_damage(apply_ai_damage),
    .apply_p_damage(apply_p_damage), .active_trainer(active_trainer), .target(target),
    .p_heal(p_heal), .catch(catch), .catch_fail(catch_fail), .caught(caught),
    .victory(victory), .loss(loss), .p_hp(p_hp[0]), .ai_hp(ai_hp[0]), .p_dead(p_dead[0]),
    .ai_dead(ai_dead[0]), .catch_success(catch_success[0]), .last_dmg(last_dmg[0]),
    .turn_count(turn_count[0]), .heals_left(heals_left[0]), .heal_denied(heal_denied[0]),
    .fail_count(fail_count[0]), .cmd_err(cmd_err[0]));

  battle_datapath #(.VAR_EN(1), .CATCH_BASE(0)) dut1 (
    .clk(clk), .reset(reset), .load_ai_hp(load_ai_hp), .apply_ai_damage(apply_ai_damage),
    .apply_p_damage(apply_p_damage), .active_trainer(active_trainer), .target(target),
    .p_heal(p_heal), .catch(catch), .catch_fail(catch_fail), .caught(caught),
    .victory(victory), .loss(loss), .p_hp(p_hp[1]), .ai_hp(ai_hp[1]), .p_dead(p_dead[1]),
    .ai_dead(ai_dead[1]), .catch_success(catch_success[1]), .last_dmg(last_dmg[1]),
    .turn_count(turn_count[1]), .heals_left(heals_left[1]), .heal_denied(heal_denied[1]),
    .fail_count(fail_count[1]), .cmd_err(cmd_err[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int lfsr_step(input int l);
    return (l >> 1) ^ (((l & 1) != 0) ? 32'hB400 : 0);
  endfunction

  function automatic int exp_catch(input int k);
    int t;
    t = m_cb[k] + 100 - m_ai[k];
    if (t > 255) t = 255;
    return (catch && m_frz[k] == 0 && t != 0 && (m_lfsr % 256) <= t) ? 1 : 0;
  endfunction

  // One clock edge of the battle rules applied to both model instances
  task automatic model_step();
    int v, d, p;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_p[k] = 100; m_ai[k] = 100; m_last[k] = 0; m_turn[k] = 0; m_fail[k] = 0;
        m_heals[k] = 3; m_den[k] = 0; m_err[k] = 0; m_frz[k] = 0;
      end else begin
        m_den[k] = 0;
        if (m_frz[k] == 0 && !(victory || loss || caught)) begin
          v = (m_var[k] != 0) ? (m_lfsr % 8) : 0;
          p = m_p[k];
          if (p_heal) begin
            if (m_heals[k] > 0) begin
              p = (p + 30 > 100) ? 100 : p + 30;
              m_heals[k]--;
            end else m_den[k] = 1;
          end
          if (apply_p_damage) begin
            if (!target && active_trainer) begin
              d = 15 + v; p = (p > d) ? p - d : 0; m_last[k] = d;
            end else m_err[k] = 1;
            if (m_turn[k] < 255) m_turn[k]++;
          end
          m_p[k] = p;
          if (apply_ai_damage) begin
            if (target && !active_trainer) begin
              if (!load_ai_hp) begin
                d = 20 + v; m_ai[k] = (m_ai[k] > d) ? m_ai[k] - d : 0; m_last[k] = d;
              end
            end else m_err[k] = 1;
          end
          if (load_ai_hp) m_ai[k] = 100;
          if (catch_fail && m_fail[k] < 255) m_fail[k]++;
        end
        if (victory || loss || caught) m_frz[k] = 1;
      end
    end
    m_lfsr = reset ? 32'hACE1 : lfsr_step(m_lfsr);
  endtask

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("p_hp%0d", k), p_hp[k], m_p[k]);
      chk($sformatf("ai_hp%0d", k), ai_hp[k], m_ai[k]);
      chk($sformatf("p_dead%0d", k), p_dead[k], (m_p[k] == 0));
      chk($sformatf("ai_dead%0d", k), ai_dead[k], (m_ai[k] == 0));
      chk($sformatf("last_dmg%0d", k), last_dmg[k], m_last[k]);
      chk($sformatf("turn%0d", k), turn_count[k], m_turn[k]);
      chk($sformatf("heals%0d", k), heals_left[k], m_heals[k]);
      chk($sformatf("denied%0d", k), heal_denied[k], m_den[k]);
      chk($sformatf("fails%0d", k), fail_count[k], m_fail[k]);
      chk($sformatf("cmd_err%0d", k), cmd_err[k], m_err[k]);
    end
  endtask

  // Drive one cycle of strobes, check the same-cycle catch result, clock, then check state
  task automatic applyStimulus(input logic ld, input logic aai, input logic ap, input logic at,
                               input logic tg, input logic hl, input logic ct,
                               input logic cf, input logic vic);
    load_ai_hp = ld; apply_ai_damage = aai; apply_p_damage = ap; active_trainer = at;
    target = tg; p_heal = hl; catch = ct; catch_fail = cf; victory = vic;
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("catch%0d", k), catch_success[k], exp_catch(k));
    @(posedge clk);
    model_step();
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int ai_seq [6] = '{80, 60, 40, 20, 0, 0};
    int hp_seq [4] = '{85, 100, 100, 100};
    int r;
    caught = 0; loss = 0; seen = 0;
    m_lfsr = 32'hACE1;
    reset = 1;
    idle();
    idle();
    reset = 0;
    chk("rst_p_hp", p_hp[0], 100);
    chk("rst_heals", heals_left[0], 3);

    // Deterministic attack on the AI
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 0);
      chk($sformatf("det_ai_hp_%0d", i), ai_hp[0], ai_seq[i]);
      chk($sformatf("det_ai_dead_%0d", i), ai_dead[0], (i >= 4));
    end
    chk("det_last_dmg", last_dmg[0], 20);

    // Rounds then heals
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
    chk("round_p_hp", p_hp[0], 55);
    chk("round_turns", turn_count[0], 3);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
      chk($sformatf("heal_hp_%0d", i), p_hp[0], hp_seq[i]);
      chk($sformatf("heal_denied_%0d", i), heal_denied[0], (i == 3));
    end
    chk("heals_zero", heals_left[0], 0);
    idle();
    chk("denied_one_cycle", heal_denied[0], 0);

    // Protocol error
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("err_ai_hp", ai_hp[0], 100);
    chk("err_set", cmd_err[0], 1);
    idle();
    idle();
    chk("err_sticky", cmd_err[0], 1);

    // Catch thresholds
    catch = 1;
    #1;
    chk("catch_base255", catch_success[0], 1);
    chk("catch_base0", catch_success[1], 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("fail_count", fail_count[0], 1);

    // Freeze then reset
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 1, 1, 1, 0, 0);
    chk("frz_ai_hp", ai_hp[0], 100);
    chk("frz_denied", heal_denied[0], 0);
    chk("frz_catch", catch_success[0], 0);
    reset = 1;
    idle();
    reset = 0;
    chk("rst2_p_hp", p_hp[0], 100);
    chk("rst2_ai_hp", ai_hp[0], 100);
    chk("rst2_heals", heals_left[0], 3);
    catch = 1;
    #1;
    chk("rst2_unfrozen", catch_success[0], 1);

    // Randomised battle with variance
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (m_ai[1] == 0) r = 7;
      case (r)
        5: applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
        6: applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
        7: applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        8: applyStimulus(0, 0, 0, 0, 0, 0, 1, 1'($urandom), 0);
        9: applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0, 0, 0, 0);
        default: begin
          applyStimulus(0, 1, 0, 0, 1, 0, 1'($urandom), 0, 0);
          chk("var_range", (last_dmg[1] >= 20 && last_dmg[1] <= 27), 1);
          if (last_dmg[1] >= 20 && last_dmg[1] <= 27) seen |= 1 << (last_dmg[1] - 20);
        end
      endcase
    end
    chk("var_all8", seen, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
